uart_tx_buffered: RTL and testbench

Consumer stage for the game-event byte stream produced by the data-send aggregator. It detects each new non-zero byte on data_send and queues it in a small FIFO. It then serialises the bytes onto the UART line as 8N1 frames and reports back-pressure through data_ready. It sits between the aggregator and the board's TX pin.

---
 rtl/uart_tx_buffered.sv | 158 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: edge-detects non-zero bytes on data_send,
// queues them in a small FIFO and serialises them LSB first onto tx.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 2
) (
    input  logic       uart_clk,
    input  logic       rst_n,
    input  logic [7:0] data_send,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_reg;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_reg;
    logic [ADDR_W-1:0]  rd_ptr_reg;
    logic [ADDR_W:0]    count_reg;
    logic [7:0]         prev_in_reg;
    logic [7:0]         shift_reg;
    logic [2:0]         bit_cnt_reg;
    logic [BAUD_W-1:0]  baud_cnt_reg;
    logic               tx_reg;
    logic               busy_reg;
    logic               overflow_reg;

    logic new_byte;
    logic fifo_full;
    logic fifo_nonempty;
    logic baud_last;
    logic pop;
    logic push;

    assign new_byte      = (data_send != 8'd0) && (data_send != prev_in_reg);
    assign fifo_full     = (count_reg == DEPTH_CNT);
    assign fifo_nonempty = (count_reg != '0);
    assign baud_last     = (baud_cnt_reg == BAUD_LAST);
    // The FIFO is drained only when idle or on the final stop-bit cycle.
    assign pop  = fifo_nonempty && ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));
    assign push = new_byte && (!fifo_full || pop);

    assign data_ready = !fifo_full;
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign overflow   = overflow_reg;

    always_ff @(posedge uart_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_send;
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_in_reg  <= 8'd0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            prev_in_reg <= data_send;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (new_byte && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= 8'd0;
            bit_cnt_reg  <= 3'd0;
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    tx_reg       <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= 3'd0;
                        tx_reg       <= shift_reg[0];
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= shift_reg >> 1;
                        if (bit_cnt_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            tx_reg      <= shift_reg[1];
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            tx_reg    <= 1'b0;
                            state_reg <= START;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised and directed bench for uart_tx_buffered against a frame-level
// reference model (byte queue plus position within a 10-bit frame).
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       uart_clk = 1'b0;
    logic       rst_n    = 1'b1;
    logic [7:0] data_send = 8'd0;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic       overflow;

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_W      (2)
    ) dut (
        .uart_clk  (uart_clk),
        .rst_n     (rst_n),
        .data_send (data_send),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 uart_clk = ~uart_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] q_model[$];
    logic [7:0] m_prev;
    logic [7:0] m_byte;
    bit         m_active;
    bit         m_ovf;
    int         m_t;
    int         frames_done = 0;
    int         busy_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_t / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    task automatic model_reset();
        q_model.delete();
        m_prev   = 8'd0;
        m_byte   = 8'd0;
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_t      = 0;
    endtask

    task automatic model_edge(input logic [7:0] d);
        bit pop;
        pop = (q_model.size() > 0) && (!m_active || m_t == FRAME - 1);
        if (m_active) begin
            if (m_t == FRAME - 1) begin
                $display("frame %0d sent byte=%02h", frames_done, m_byte);
                frames_done++;
                if (pop) begin
                    m_byte = q_model.pop_front();
                    m_t = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_t++;
            end
        end else if (pop) begin
            m_active = 1'b1;
            m_byte = q_model.pop_front();
            m_t = 0;
        end
        if (d != 8'd0 && d != m_prev) begin
            if (q_model.size() < DEPTH) q_model.push_back(d);
            else m_ovf = 1'b1;
        end
        m_prev = d;
    endtask

    task automatic check_outputs(input string ph);
        check_val({ph, ".tx"}, tx, exp_tx());
        check_val({ph, ".busy"}, busy, m_active);
        check_val({ph, ".data_ready"}, data_ready, q_model.size() != DEPTH);
        check_val({ph, ".overflow"}, overflow, m_ovf);
    endtask

    task automatic tick(input logic [7:0] d);
        data_send = d;
        @(posedge uart_clk);
        model_edge(d);
        #1;
        if (busy) busy_cnt++;
        check_outputs("cyc");
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_active || q_model.size() > 0) && guard < 2000) begin
            tick(8'd0);
            guard++;
        end
        check_val("drain_bound", guard < 2000, 1);
    endtask

    initial begin
        int f0;
        int guard;
        logic [7:0] d;
        logic [7:0] last_d;

        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_outputs("reset");
        repeat (2) @(posedge uart_clk);
        #1;
        check_outputs("reset_hold");
        rst_n = 1'b1;
        tick(8'd0);

        // Single frame of 0x5A held for three cycles
        busy_cnt = 0;
        f0 = frames_done;
        tick(8'h5A);
        check_val("t1_capture_tx", tx, 1);
        tick(8'h5A);
        check_val("t1_start_tx", tx, 0);
        tick(8'h5A);
        tick(8'h00);
        drain();
        check_val("t1_busy_cycles", busy_cnt, 40);
        check_val("t1_frames", frames_done - f0, 1);
        check_val("t1_empty", data_ready, 1);

        // Back-to-back frames
        busy_cnt = 0;
        f0 = frames_done;
        tick(8'h11); tick(8'h22); tick(8'h33); tick(8'h00);
        drain();
        check_val("t2_busy_cycles", busy_cnt, 120);
        check_val("t2_frames", frames_done - f0, 3);

        // Repeated value only re-queued after an intervening zero
        f0 = frames_done;
        tick(8'h07); tick(8'h07); tick(8'h00); tick(8'h07); tick(8'h00);
        drain();
        check_val("t3_frames", frames_done - f0, 2);

        // Overflow: six distinct bytes while idle
        f0 = frames_done;
        tick(8'hA1); tick(8'hA2); tick(8'hA3); tick(8'hA4); tick(8'hA5);
        check_val("t4_full_ready", data_ready, 0);
        check_val("t4_no_ovf_yet", overflow, 0);
        tick(8'hA6);
        check_val("t4_ovf", overflow, 1);
        tick(8'h00);
        drain();
        check_val("t4_frames", frames_done - f0, 5);
        check_val("t4_ovf_sticky", overflow, 1);

        // Asynchronous reset during data bit 3 with two bytes queued
        f0 = frames_done;
        tick(8'h3C); tick(8'h44); tick(8'h55); tick(8'h00);
        guard = 0;
        while (!(m_active && m_t == 4 * CPB + 1) && guard < 200) begin
            tick(8'h00);
            guard++;
        end
        check_val("t5_wait_bound", guard < 200, 1);
        check_val("t5_queued", q_model.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("t5_async_tx", tx, 1);
        check_outputs("t5_reset");
        @(posedge uart_clk);
        #1;
        check_outputs("t5_reset_hold");
        rst_n = 1'b1;
        repeat (60) tick(8'h00);
        check_val("t5_no_frames", frames_done - f0, 0);

        // Pop at the end of STOP coinciding with a write into a full FIFO
        f0 = frames_done;
        tick(8'h61); tick(8'h62); tick(8'h63); tick(8'h64); tick(8'h65);
        check_val("t6_full", data_ready, 0);
        guard = 0;
        while (!(m_active && m_t == FRAME - 1) && guard < 200) begin
            tick(8'h00);
            guard++;
        end
        check_val("t6_wait_bound", guard < 200, 1);
        tick(8'h66);
        check_val("t6_still_full", data_ready, 0);
        check_val("t6_no_ovf", overflow, 0);
        tick(8'h00);
        drain();
        check_val("t6_frames", frames_done - f0, 6);

        // Randomised traffic
        last_d = 8'h00;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) d = 8'h00;
            else if (r < 6) d = last_d;
            else d = 8'($urandom_range(1, 255));
            tick(d);
            last_d = d;
        end
        tick(8'h00);
        drain();
        check_val("rand_idle_tx", tx, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
